// File: rtl/logicnet_input_packer.sv
// logicnet_input_packer
//   Packs a stream of quantized feature codes (FEAT_BITS each) into one
//   OUT_W-bit input vector for the first LogicNet layer.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. s_ready may depend combinationally on m_ready and rst. Once
//   m_valid is high it stays high, and m_data stays stable, until the edge
//   where m_ready is high.
//
// Ports
//   clk, rst    : clock and synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : feature code input stream
//   m_valid/m_ready/m_data        : packed word output (feature 0 in the LSBs)
//   err_short   : one-cycle pulse, s_last seen before NUM_FEAT beats
//   err_long    : one-cycle pulse, NUM_FEAT-th beat seen without s_last
//   sample_cnt  : number of words handed off downstream (wraps)
module logicnet_input_packer #(
  parameter int FEAT_BITS = 2,
  parameter int NUM_FEAT  = 3,
  localparam int OUT_W    = FEAT_BITS * NUM_FEAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [FEAT_BITS-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_W-1:0]     m_data,
  output logic                 err_short,
  output logic                 err_long,
  output logic [15:0]          sample_cnt
);

  localparam int IW = $clog2(NUM_FEAT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FEAT - 1);

  logic [IW-1:0]    idx;
  logic [OUT_W-1:0] asm_q;
  logic             at_last;
  logic             accept;
  logic             handoff;
  logic [OUT_W-1:0] merged;

  always_comb begin
    at_last = (idx == LAST_IDX);
    // Only the final beat needs room in the output register; earlier beats
    // go into the assembly register and can always be taken.
    s_ready = !rst && (!at_last || !m_valid || m_ready);
    accept  = s_valid && s_ready;
    handoff = m_valid && m_ready;
    merged  = asm_q;
    merged[(NUM_FEAT-1)*FEAT_BITS +: FEAT_BITS] = s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      asm_q      <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      sample_cnt <= 16'd0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;

      if (handoff) begin
        sample_cnt <= sample_cnt + 16'd1;
        m_valid    <= 1'b0;
      end

      if (accept) begin
        if (at_last) begin
          // Completing a word overrides the handoff clear above, so a word
          // handed off and a new word loaded share one edge.
          m_data   <= merged;
          m_valid  <= 1'b1;
          idx      <= '0;
          asm_q    <= '0;
          err_long <= !s_last;
        end else if (s_last) begin
          // Early end of sample: drop the partial word entirely.
          idx       <= '0;
          asm_q     <= '0;
          err_short <= 1'b1;
        end else begin
          asm_q[idx*FEAT_BITS +: FEAT_BITS] <= s_data;
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_logicnet_input_packer.sv
module tb_logicnet_input_packer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [5:0]  m_data;
  logic        err_short;
  logic        err_long;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  logicnet_input_packer dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .err_short  (err_short),
    .err_long   (err_long),
    .sample_cnt (sample_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic send_beat(input logic [1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = 2'b00; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 6'd0) begin errors++; $display("FAIL reset_m_data: got %b want 000000", m_data); end
    checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b want 00", err_short, err_long); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", sample_cnt); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_nominal;
    m_ready = 1'b1;
    send_beat(2'b01, 1'b0);
    send_beat(2'b10, 1'b0);
    send_beat(2'b11, 1'b1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL nominal_valid: got %b want 1", m_valid); end
    checks++; if (m_data !== 6'b111001) begin errors++; $display("FAIL nominal_data: got %b want 111001", m_data); end
    checks++; if (err_short !== 1'b0 || err_long !== 1'b0) begin errors++; $display("FAIL nominal_err: got %b%b want 00", err_short, err_long); end
    idle(1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL nominal_drop: got %b want 0", m_valid); end
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL nominal_cnt: got %0d want 1", sample_cnt); end
  endtask

  task automatic test_backpressure;
    m_ready = 1'b0;
    send_beat(2'b01, 1'b0);
    send_beat(2'b10, 1'b0);
    send_beat(2'b11, 1'b1);
    send_beat(2'b00, 1'b0);
    send_beat(2'b11, 1'b0);
    s_valid = 1'b1; s_data = 2'b01; s_last = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready_low: got %b want 0", s_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 6'b111001) begin errors++; $display("FAIL bp_hold: got %b/%b want 1/111001", m_valid, m_data); end
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL bp_hold_cnt: got %0d want 1", sample_cnt); end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_s_ready_high: got %b want 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 2'b00;
    checks++; if (m_valid !== 1'b1 || m_data !== 6'b011100) begin errors++; $display("FAIL bp_word2: got %b/%b want 1/011100", m_valid, m_data); end
    checks++; if (sample_cnt !== 16'd2) begin errors++; $display("FAIL bp_cnt2: got %0d want 2", sample_cnt); end
    idle(1);
    checks++; if (m_valid !== 1'b0 || sample_cnt !== 16'd3) begin errors++; $display("FAIL bp_drain: got %b/%0d want 0/3", m_valid, sample_cnt); end
  endtask

  task automatic test_short;
    m_ready = 1'b1;
    send_beat(2'b11, 1'b1);
    checks++; if (err_short !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL short_pulse: got err=%b valid=%b want 1/0", err_short, m_valid); end
    idle(1);
    checks++; if (err_short !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL short_clear: got err=%b valid=%b want 0/0", err_short, m_valid); end
    send_beat(2'b00, 1'b0);
    send_beat(2'b00, 1'b0);
    send_beat(2'b01, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== 6'b010000) begin errors++; $display("FAIL short_next: got %b/%b want 1/010000", m_valid, m_data); end
    idle(1);
    checks++; if (sample_cnt !== 16'd4) begin errors++; $display("FAIL short_cnt: got %0d want 4", sample_cnt); end
  endtask

  task automatic test_long;
    m_ready = 1'b1;
    send_beat(2'b10, 1'b0);
    send_beat(2'b10, 1'b0);
    send_beat(2'b10, 1'b0);
    checks++; if (m_valid !== 1'b1 || m_data !== 6'b101010) begin errors++; $display("FAIL long_word: got %b/%b want 1/101010", m_valid, m_data); end
    checks++; if (err_long !== 1'b1 || err_short !== 1'b0) begin errors++; $display("FAIL long_pulse: got long=%b short=%b want 1/0", err_long, err_short); end
    send_beat(2'b01, 1'b0);
    checks++; if (err_long !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL long_clear: got long=%b valid=%b want 0/0", err_long, m_valid); end
    send_beat(2'b00, 1'b0);
    send_beat(2'b00, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== 6'b000001 || err_long !== 1'b0) begin errors++; $display("FAIL long_restart: got %b/%b/%b want 1/000001/0", m_valid, m_data, err_long); end
    idle(1);
    checks++; if (sample_cnt !== 16'd6) begin errors++; $display("FAIL long_cnt: got %0d want 6", sample_cnt); end
  endtask

  task automatic test_reset_mid;
    m_ready = 1'b1;
    send_beat(2'b11, 1'b0);
    send_beat(2'b11, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 6'd0 || sample_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_out: got %b/%b/%0d want 0/000000/0", m_valid, m_data, sample_cnt); end
    checks++; if (err_short !== 1'b0 || err_long !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got %b%b ready=%b want 00 ready=0", err_short, err_long, s_ready); end
    rst = 1'b0;
    idle(1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_noword: got %b want 0", m_valid); end
    send_beat(2'b10, 1'b0);
    send_beat(2'b01, 1'b0);
    send_beat(2'b11, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== 6'b110110) begin errors++; $display("FAIL rstmid_fresh: got %b/%b want 1/110110", m_valid, m_data); end
    idle(1);
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_cnt: got %0d want 1", sample_cnt); end
  endtask

  task automatic test_back_to_back;
    m_ready = 1'b1;
    send_beat(2'b01, 1'b0);
    send_beat(2'b10, 1'b0);
    send_beat(2'b00, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== 6'b001001) begin errors++; $display("FAIL b2b_word1: got %b/%b want 1/001001", m_valid, m_data); end
    send_beat(2'b11, 1'b0);
    send_beat(2'b11, 1'b0);
    s_valid = 1'b1; s_data = 2'b11; s_last = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 2'b00;
    checks++; if (m_valid !== 1'b1 || m_data !== 6'b111111 || sample_cnt !== 16'd2) begin errors++; $display("FAIL b2b_word2: got %b/%b/%0d want 1/111111/2", m_valid, m_data, sample_cnt); end
    idle(1);
    checks++; if (sample_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt: got %0d want 3", sample_cnt); end
  endtask

  task automatic test_wrap;
    m_ready = 1'b1;
    force dut.sample_cnt = 16'hffff;
    #1;
    release dut.sample_cnt;
    #1;
    checks++; if (sample_cnt !== 16'hffff) begin errors++; $display("FAIL wrap_preload: got %h want ffff", sample_cnt); end
    send_beat(2'b01, 1'b0);
    send_beat(2'b01, 1'b0);
    send_beat(2'b01, 1'b1);
    checks++; if (m_data !== 6'b010101) begin errors++; $display("FAIL wrap_word: got %b want 010101", m_data); end
    idle(1);
    checks++; if (sample_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h want 0000", sample_cnt); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_backpressure;
    test_short;
    test_long;
    test_reset_mid;
    test_back_to_back;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logicnet_input_packer.md
LOGICNET_INPUT_PACKER -- requirements
Module: logicnet_input_packer

Interface
REQ-001 SHALL have parameter FEAT_BITS, default 2: bit width of one quantized input feature code.
REQ-002 SHALL have parameter NUM_FEAT, default 3: feature codes packed per output word (range 2..16).
REQ-003 SHALL derive OUT_W = FEAT_BITS*NUM_FEAT, default 6, matching the layer0 neuron input vector width.
REQ-004 Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- s_valid  input  1  feature code present.
- s_ready  output  1  packer accepts the feature code this cycle.
- s_data  input  FEAT_BITS  quantized feature code.
- s_last  input  1  beat carries the final feature of a sample.
- m_valid  output  1  packed word available.
- m_ready  input  1  downstream neuron layer consumes the word.
- m_data  output  OUT_W  packed feature vector (layer0 input vector M0).
- err_short  output  1  one-cycle pulse: s_last arrived before NUM_FEAT beats.
- err_long  output  1  one-cycle pulse: NUM_FEAT-th beat arrived without s_last.
- sample_cnt  output  16  count of words handed off downstream.

Function
REQ-005 SHALL treat a beat as accepted when s_valid and s_ready are both high on a rising edge; a word is handed off when m_valid and m_ready are both high.
REQ-006 SHALL place accepted beat k (0-based within a sample) at m_data[k*FEAT_BITS +: FEAT_BITS], so feature 0 occupies the LSBs.
REQ-007 SHALL hold a beat index counter IDX (0..NUM_FEAT-1) and an assembly register ASM of width OUT_W.
REQ-008 SHALL keep s_ready high when IDX < NUM_FEAT-1; when IDX = NUM_FEAT-1, s_ready is high only if m_valid is low or m_ready is high in that cycle.
REQ-009 SHALL, on an accepted beat with IDX = NUM_FEAT-1, load m_data with ASM merged with the current beat in the same edge, set m_valid, and reset IDX to 0. Output latency is one cycle from the final accepted beat.
REQ-010 SHALL clear m_valid on handoff unless a new word loads on the same edge; in that case m_valid stays high and m_data takes the new word.
REQ-011 SHALL keep m_data and m_valid stable while m_valid is high and m_ready is low.
REQ-012 SHALL sustain one accepted beat per cycle and one word per NUM_FEAT cycles when m_ready is held high.
REQ-013 SHALL, on an accepted beat with s_last high and IDX < NUM_FEAT-1:
- discard the partial word in ASM;
- reset IDX to 0;
- pulse err_short for one cycle;
- emit no word.
REQ-014 SHALL, on an accepted beat with IDX = NUM_FEAT-1 and s_last low, emit the word normally, pulse err_long for one cycle, and restart at IDX = 0.
REQ-015 SHALL clear the unused ASM bits when IDX returns to 0, so no stale feature bits leak into the next word.
REQ-016 SHALL increment sample_cnt by 1 on each handoff; the count wraps from 0xFFFF to 0x0000.
REQ-017 SHALL ignore s_data and s_last on cycles where no beat is accepted.

Reset
REQ-018 SHALL, when rst is high at a clock edge, set the following, regardless of any in-flight beat or pending word:
- IDX = 0, ASM = 0;
- m_valid = 0, m_data = 0;
- err_short = 0, err_long = 0;
- sample_cnt = 0.
REQ-019 SHALL drive s_ready low while rst is high, and high on the first cycle after rst deasserts.
REQ-020 SHALL discard a partially assembled sample on reset and emit no word from it.

Verification
REQ-021 Nominal: with m_ready=1, send beats 2'b01, 2'b10, 2'b11 (s_last on the third) -> next cycle m_valid=1, m_data=6'b111001, sample_cnt=1, no error pulse.
REQ-022 Backpressure: m_ready=0 with a word pending, then send a full second sample -> s_ready drops at IDX=2; first word is held stable; raising m_ready hands off word 1 and loads word 2 on the same edge with m_valid held high.
REQ-023 Short frame: send 2'b11 with s_last=1 at IDX=0 -> err_short pulses one cycle; no m_valid; next sample 0,0,1 produces m_data=6'b010000.
REQ-024 Long frame: three beats 2'b10 with s_last=0 -> word 6'b101010 is emitted, err_long pulses one cycle, and the next beat is packed at IDX=0.
REQ-025 Reset mid-sample: after two accepted beats assert rst for one cycle -> no word is emitted, all outputs are 0, and a fresh 3-beat sample packs correctly.
REQ-026 Wrap: preload 65535 handoffs, or force sample_cnt = 0xFFFF, then hand off one word -> sample_cnt = 0x0000.
